proc_dout_uart_tx: RTL

Downstream output stage for the 16-bit `processor`. It accepts each word the processor strobes onto `dout` and buffers it in a small FIFO. Each word is then serialized onto a single UART line, low byte first, so processor output can be observed off-chip or by a bench UART receiver.

---
 rtl/proc_io_pkg.sv | 9 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/proc_dout_uart_tx.sv | 131 +++++++++++++
 3 files changed

// File: rtl/proc_io_pkg.sv
// Shared types and framing constants for the processor output UART stage.
package proc_io_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned WORD_BYTES = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/proc_dout_uart_tx.sv
// Buffers processor output words and serializes each as two 8N1 UART frames, low byte first.
module proc_dout_uart_tx
  import proc_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DEPTH        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic        full,
  output logic        busy,
  output logic        overflow,
  output logic        tx
);

  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEPTH);

  tx_state_t   state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]  bit_q;
  logic        byte_sel_q;
  logic [15:0] sr_q;
  logic        tx_q;
  logic        busy_q;
  logic        ovf_q;

  logic          fifo_push;
  logic          fifo_pop;
  logic [15:0]   fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          baud_done;

  // Acceptance uses the pre-edge count, so a same-cycle pop never makes room.
  assign fifo_push = wr_en && (fifo_count < CNT_MAX);
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;
  assign baud_done = (baud_q == BAUD_LAST);

  sync_fifo #(
    .WIDTH(16),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .wdata(wr_data),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_sel_q <= 1'b0;
      sr_q       <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      // Line and busy follow the state one cycle later, keeping both glitch-free.
      case (state_q)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= sr_q[0];
        default: tx_q <= 1'b1;
      endcase
      busy_q <= (state_q != IDLE);
      if (wr_en && !fifo_push) ovf_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            sr_q       <= fifo_rdata;
            byte_sel_q <= 1'b0;
            bit_q      <= '0;
            baud_q     <= '0;
            state_q    <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_q  <= '0;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_q <= '0;
            sr_q   <= {1'b0, sr_q[15:1]};
            bit_q  <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_q <= '0;
            if (!byte_sel_q) begin
              byte_sel_q <= 1'b1;
              state_q    <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign full     = fifo_full;
  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign tx       = tx_q;

endmodule
